// File: rtl/load_store_unit.sv
// Load/store unit: accepts one pipeline memory request at a time, pre-checks alignment and
// mode, strobes memory, waits READ_LATENCY cycles for loads and holds the response until taken.
module load_store_unit #(
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_ReqValid,
  output logic        o_ReqReady,
  input  logic        i_ReqWrite,
  input  logic [31:0] i_ReqAddress,
  input  logic [31:0] i_ReqData,
  input  logic [2:0]  i_ReqMode,
  output logic        o_RespValid,
  input  logic        i_RespReady,
  output logic [31:0] o_RespData,
  output logic        o_RespMisaligned,
  output logic        o_RespBadMode,
  output logic        o_MemWriteEnable,
  output logic        o_MemReadEnable,
  output logic [31:0] o_MemAddress,
  output logic [31:0] o_MemDataOut,
  output logic [2:0]  o_MemMode,
  input  logic [31:0] i_MemDataIn,
  input  logic        i_MemMisaligned,
  input  logic        i_MemBadInstruction
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [1:0] LatCnt  = 2'(READ_LATENCY);
  localparam bit         HasWait = (READ_LATENCY != 0);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  mode_q, mode_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_mis_q, resp_mis_d;
  logic        resp_bad_q, resp_bad_d;

  logic pre_mis, pre_bad, capture, mem_err;

  always_comb begin
    pre_mis = ((i_ReqMode[1:0] == 2'b01) && i_ReqAddress[0]) ||
              ((i_ReqMode[1:0] == 2'b10) && (i_ReqAddress[1:0] != 2'b00));
    if (i_ReqWrite) begin
      pre_bad = (i_ReqMode > 3'b010);
    end else begin
      pre_bad = (i_ReqMode == 3'b011) || (i_ReqMode == 3'b110) || (i_ReqMode == 3'b111);
    end
  end

  assign mem_err = i_MemMisaligned || i_MemBadInstruction;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mode_d      = mode_q;
    resp_data_d = resp_data_q;
    resp_mis_d  = resp_mis_q;
    resp_bad_d  = resp_bad_q;
    capture     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_ReqValid) begin
          write_d = i_ReqWrite;
          addr_d  = i_ReqAddress;
          data_d  = i_ReqData;
          mode_d  = i_ReqMode;
          if (pre_mis || pre_bad) begin
            resp_data_d = 32'h0;
            resp_mis_d  = pre_mis;
            resp_bad_d  = pre_bad;
            state_d     = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        // Stores never wait for read latency.
        if (write_q || !HasWait) begin
          capture = 1'b1;
        end else begin
          cnt_d   = LatCnt;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 2'd1) begin
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StResp: begin
        if (i_RespReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      cnt_d       = 2'd0;
      resp_mis_d  = i_MemMisaligned;
      resp_bad_d  = i_MemBadInstruction;
      resp_data_d = (write_q || mem_err) ? 32'h0 : i_MemDataIn;
      state_d     = StResp;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      write_q     <= 1'b0;
      addr_q      <= 32'h0;
      data_q      <= 32'h0;
      mode_q      <= 3'b000;
      resp_data_q <= 32'h0;
      resp_mis_q  <= 1'b0;
      resp_bad_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      resp_data_q <= resp_data_d;
      resp_mis_q  <= resp_mis_d;
      resp_bad_q  <= resp_bad_d;
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them immediately.
  assign o_ReqReady       = (state_q == StIdle);
  assign o_RespValid      = (state_q == StResp);
  assign o_MemWriteEnable = (state_q == StIssue) && write_q;
  assign o_MemReadEnable  = ((state_q == StIssue) || (state_q == StWait)) && !write_q;
  assign o_MemAddress     = addr_q;
  assign o_MemDataOut     = data_q;
  assign o_MemMode        = mode_q;
  assign o_RespData       = resp_data_q;
  assign o_RespMisaligned = resp_mis_q;
  assign o_RespBadMode    = resp_bad_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter READ_LATENCY, default 0, range 0..3: extra cycles after the issue cycle before memory read data and error flags are valid.
REQ-002 i_Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 i_Reset_n  input  1  asynchronous, active-low reset.
REQ-004 i_ReqValid  input  1  pipeline request valid.
REQ-005 o_ReqReady  input-side handshake output  1  unit idle and able to accept a request.
REQ-006 i_ReqWrite  input  1  1 = store, 0 = load.
REQ-007 i_ReqAddress  input  32  byte address.
REQ-008 i_ReqData  input  32  store data, right-aligned.
REQ-009 i_ReqMode  input  3  RISC-V funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-010 o_RespValid  output  1  response valid.
REQ-011 i_RespReady  input  1  pipeline accepts response.
REQ-012 o_RespData  output  32  load result as returned by memory; 0 for stores and errors.
REQ-013 o_RespMisaligned  output  1  access was misaligned.
REQ-014 o_RespBadMode  output  1  mode illegal for the access direction.
REQ-015 o_MemWriteEnable, o_MemReadEnable  output  1 each  memory strobes.
REQ-016 o_MemAddress, o_MemDataOut  output  32 each; o_MemMode  output  3: memory request fields.
REQ-017 i_MemDataIn  input  32; i_MemMisaligned, i_MemBadInstruction  input  1 each: memory read data and error flags.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, RESP; o_ReqReady SHALL equal (state == IDLE).
REQ-019 Accept occurs on an edge with i_ReqValid && o_ReqReady; write flag, address, data, mode SHALL be registered at that edge and held stable until return to IDLE.
REQ-020 Pre-check at accept: misaligned = (mode[1:0]==01 && addr[0]) || (mode[1:0]==10 && addr[1:0]!=0); bad mode = load with mode in {011,110,111} or store with mode > 010.
REQ-021 Pre-check failure SHALL go IDLE -> RESP directly, no memory strobe, o_RespData = 0, corresponding flag(s) set.
REQ-022 Otherwise IDLE -> ISSUE; in ISSUE exactly one of o_MemWriteEnable / o_MemReadEnable SHALL be high, for exactly one cycle for stores.
REQ-023 Loads: o_MemReadEnable SHALL stay high through ISSUE and all WAIT cycles; ISSUE -> WAIT when READ_LATENCY > 0, with a down-counter loaded with READ_LATENCY; WAIT -> RESP when counter reaches 1.
REQ-024 Capture edge = end of ISSUE (READ_LATENCY 0) or end of last WAIT cycle; at that edge i_MemDataIn, i_MemMisaligned, i_MemBadInstruction SHALL be registered into the response.
REQ-025 Stores SHALL go ISSUE -> RESP regardless of READ_LATENCY, sampling memory error flags at end of ISSUE; o_RespData = 0.
REQ-026 Any memory error flag set SHALL force o_RespData = 0.
REQ-027 o_RespValid = (state == RESP); response fields SHALL hold until the edge with i_RespReady high, then RESP -> IDLE.
REQ-028 Latency (READ_LATENCY 0, i_RespReady held high): accept edge E0, o_RespValid high in cycle after E1, next accept no earlier than E3.
REQ-029 Memory strobes SHALL be low in IDLE, RESP; o_MemAddress/o_MemDataOut/o_MemMode SHALL reflect the registered request at all times.
REQ-030 i_ReqValid while not ready SHALL be ignored; requests are never dropped once accepted.

Reset
REQ-031 i_Reset_n low SHALL immediately force IDLE, counter 0, all registered request/response fields 0, all outputs 0 except o_ReqReady = 1.
REQ-032 Reset mid-ISSUE/WAIT SHALL deassert memory strobes asynchronously; the in-flight request is discarded with no response.

Verification
REQ-033 LW addr 0x100, memory returns 0xDEADBEEF, L=0 -> one read strobe cycle, o_RespData 0xDEADBEEF, flags 0, o_RespValid one cycle after capture.
REQ-034 SH addr 0x0102 data 0x1234ABCD -> single write strobe, o_MemMode 001, o_MemDataOut 0x1234ABCD, response data 0, flags 0.
REQ-035 LH addr 0x0103 -> no memory strobe, o_RespMisaligned 1, o_RespData 0; store mode 111 -> o_RespBadMode 1, no strobe.
REQ-036 READ_LATENCY 3, LBU addr 0x7 -> read strobe high 4 consecutive cycles, data captured at end of 4th, i_RespReady low 5 cycles -> response held stable.
REQ-037 Assert i_Reset_n low during WAIT -> strobes drop same cycle, no o_RespValid, next request after release behaves normally.
